neuron_mac: RTL
===============

NEURON_MAC -- requirements
Module: neuron_mac

Interface
REQ-001 SHALL have parameter N_INPUTS, default 4, number of input beats per neuron (range 1..255).
REQ-002 SHALL have parameter FRAC_BITS, default 8, fractional bits of the signed Q8.8 data format.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a neuron evaluation.
REQ-006 SHALL have port bias  input  16  signed Q8.8 bias, sampled on accepted start.
REQ-007 SHALL have port relu_en  input  1  ReLU enable, sampled on accepted start.
REQ-008 SHALL have port data_in  input  16  signed Q8.8 activation, driven by the upstream 2:1 16-bit mux output.
REQ-009 SHALL have port weight_in  input  16  signed Q8.8 weight paired with data_in.
REQ-010 SHALL have port in_valid  input  1  data_in/weight_in valid.
REQ-011 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-012 SHALL have port result  output  16  signed Q8.8 neuron output.
REQ-013 SHALL have port out_valid  output  1  result valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, BIAS, DONE.
REQ-017 IDLE -> ACCUM on start; accumulator cleared to 0, beat counter cleared to 0, bias and relu_en latched.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 in_ready SHALL be 1 only in ACCUM; a beat is accepted on a rising edge with in_valid && in_ready.
REQ-020 Each accepted beat SHALL add signed 32-bit product data_in*weight_in into a 40-bit signed accumulator and increment the counter.
REQ-021 in_valid low in ACCUM SHALL hold accumulator and counter unchanged (no timeout).
REQ-022 Acceptance of beat N_INPUTS SHALL move ACCUM -> BIAS.
REQ-023 BIAS (exactly one cycle) SHALL add sign-extended bias << FRAC_BITS to the accumulator, then go to DONE.
REQ-024 Entering DONE, result SHALL be accumulator >>> FRAC_BITS (arithmetic, truncating), saturated to [0x8000, 0x7FFF], then forced to 0x0000 if relu_en and negative.
REQ-025 out_valid SHALL assert 2 cycles after the edge accepting the last beat and stay high, with result stable, until out_ready is sampled high.
REQ-026 DONE with out_ready high SHALL return to IDLE next edge and deassert out_valid; start in that same cycle is ignored.
REQ-027 result SHALL hold its last value in IDLE and ACCUM until the next DONE.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, accumulator 0, counter 0, result 0x0000, out_valid 0, in_ready 0, busy 0.
REQ-029 Reset asserted mid-ACCUM or in DONE SHALL abandon the evaluation with no out_valid pulse after release.
REQ-030 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Structure
REQ-031 Q-format constants (DATA_W=16, FRAC_BITS=8, ACC_W=40, SAT_MAX=0x7FFF, SAT_MIN=0x8000) and the FSM state encoding SHALL live in a shared package.
REQ-032 Saturation/ReLU logic SHALL be one sub-module, q_sat_relu (40-bit in, 16-bit out, relu_en).
REQ-033 The multiplier SHALL be a single combinational 16x16 signed product; no DSP pipelining.

Verification
REQ-034 N=4, data 0x0100, weight 0x0200 x4, bias 0x0080, relu_en 0 -> result 0x0880, out_valid 2 cycles after 4th beat.
REQ-035 data 0x7FFF, weight 0x7FFF x4, bias 0x7FFF -> result 0x7FFF (positive saturation); data 0x8000, weight 0x7FFF x4 -> 0x8000.
REQ-036 data 0x0100, weight 0xFF00 x4, bias 0 -> 0xFC00 with relu_en 0; 0x0000 with relu_en 1.
REQ-037 in_valid toggled 1-0-1-0 and out_ready held low 5 cycles in DONE -> same result as REQ-034, out_valid and result stable throughout hold.
REQ-038 rst_n pulsed low after 2 beats, then fresh start with REQ-034 stimulus -> exactly one out_valid, result 0x0880.
REQ-039 start pulsed during ACCUM and during DONE -> ignored; beat count and result unaffected.

Source files
------------

// File: rtl/neuron_mac_pkg.sv
// Shared Q8.8 constants and FSM encoding for the neuron MAC.
package neuron_mac_pkg;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = 8;
    localparam int ACC_W     = 40;
    localparam int PROD_W    = 2 * DATA_W;
    localparam int CNT_W     = 8;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        DONE
    } state_t;
endpackage

// File: rtl/neuron_mac_sat_relu.sv
// Rescales the wide accumulator to Q8.8, saturates, and applies optional ReLU.
module q_sat_relu
    import neuron_mac_pkg::DATA_W, neuron_mac_pkg::ACC_W;
    import neuron_mac_pkg::SAT_MAX, neuron_mac_pkg::SAT_MIN;
#(
    parameter int FRAC_BITS = neuron_mac_pkg::FRAC_BITS
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     relu_en,
    output logic        [DATA_W-1:0] result
);
    localparam logic signed [ACC_W-1:0] HI =
        {{(ACC_W-DATA_W){SAT_MAX[DATA_W-1]}}, SAT_MAX};
    localparam logic signed [ACC_W-1:0] LO =
        {{(ACC_W-DATA_W){SAT_MIN[DATA_W-1]}}, SAT_MIN};

    logic signed [ACC_W-1:0]  shifted;
    logic        [DATA_W-1:0] sat;

    always_comb begin
        shifted = acc >>> FRAC_BITS;
        if (shifted > HI) begin
            sat = SAT_MAX;
        end else if (shifted < LO) begin
            sat = SAT_MIN;
        end else begin
            sat = shifted[DATA_W-1:0];
        end
        result = (relu_en && sat[DATA_W-1]) ? '0 : sat;
    end
endmodule

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: N weighted beats, plus bias, then ReLU/saturate.
module neuron_mac
    import neuron_mac_pkg::DATA_W, neuron_mac_pkg::ACC_W;
    import neuron_mac_pkg::PROD_W, neuron_mac_pkg::CNT_W;
    import neuron_mac_pkg::state_t;
    import neuron_mac_pkg::IDLE, neuron_mac_pkg::ACCUM;
    import neuron_mac_pkg::BIAS, neuron_mac_pkg::DONE;
#(
    parameter int N_INPUTS  = 4,
    parameter int FRAC_BITS = neuron_mac_pkg::FRAC_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       bias_q;
    logic                    relu_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic        [DATA_W-1:0] sat_val;
    logic                     last;

    assign prod     = $signed(data_in) * $signed(weight_in);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_BITS;
    assign last     = (cnt == CNT_W'(N_INPUTS - 1));

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);

    q_sat_relu #(.FRAC_BITS(FRAC_BITS)) u_sat (
        .acc    (acc),
        .relu_en(relu_q),
        .result (sat_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        cnt    <= '0;
                        bias_q <= bias;
                        relu_q <= relu_en;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + 1'b1;
                        if (last) state <= BIAS;
                    end
                end
                BIAS: begin
                    acc   <= acc + bias_ext;
                    state <= DONE;
                end
                DONE: begin
                    // First DONE cycle captures the result; later cycles wait for handshake.
                    if (!out_valid) begin
                        result    <= sat_val;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
